// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_digit_t;

    // Unsigned operands need one extra window to absorb the zero extension.
    function automatic int unsigned digit_count(input int unsigned width, input logic is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier window to {neg, two, one}.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0]   win,
    output booth_digit_t dig
);

    always_comb begin
        dig     = '0;
        dig.one = win[1] ^ win[0];
        dig.two = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
        dig.neg = win[2] & ~(win[1] & win[0]);
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned MW = WIDTH + 3;
    localparam int unsigned CW = $clog2(WIDTH / 2 + 1);

    state_t          state;
    logic [PW-1:0]   mcand;
    logic [MW-1:0]   mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   p_q;
    logic            out_valid_q;

    booth_digit_t    dig;
    logic [PW-1:0]   mag;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_sum;
    logic            ext;

    booth_digit_enc u_enc (
        .win (mplier[2:0]),
        .dig (dig)
    );

    always_comb begin
        mag     = '0;
        if (dig.two)
            mag = mcand << 1;
        else if (dig.one)
            mag = mcand;
        pp      = dig.neg ? (~mag + PW'(1)) : mag;
        acc_sum = acc + pp;
        ext     = is_signed & b[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                        mplier <= {ext, ext, b, 1'b0};
                        acc    <= '0;
                        cnt    <= CW'(digit_count(WIDTH, is_signed) - 1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0) begin
                        p_q         <= acc_sum;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=16) and the standalone Booth digit recoder.
module tb_booth_mult_seq;
    import booth_pkg::*;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int unsigned lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    logic [2:0]   win;
    booth_digit_t dig;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    vec_t        vecs[9];
    logic [2:0]  enc_exp[8];
    logic [31:0] held_p;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    booth_digit_enc u_enc_tb (
        .win (win),
        .dig (dig)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operand pair and returns the cycles until out_valid (bounded).
    task automatic start_and_wait(input logic s, input logic [15:0] ai, input logic [15:0] bi,
                                  output int unsigned cyc);
        is_signed = s;
        a         = ai;
        b         = bi;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        cyc       = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int unsigned cyc;

        vecs[0] = '{1'b1, 16'h0003, 16'h0005, 32'h0000_000F, 8};
        vecs[1] = '{1'b1, 16'hFFF9, 16'h0003, 32'hFFFF_FFEB, 8};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 8};
        vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 9};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 8};
        vecs[5] = '{1'b0, 16'h8000, 16'h0002, 32'h0001_0000, 9};
        vecs[6] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 8};
        vecs[7] = '{1'b0, 16'h00FF, 16'h0101, 32'h0000_FFFF, 9};
        vecs[8] = '{1'b0, 16'h0000, 16'h1234, 32'h0000_0000, 9};

        enc_exp = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b110, 3'b101, 3'b101, 3'b000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        win       = '0;

        for (int i = 0; i < 8; i++) begin
            win = 3'(i);
            #1;
            check($sformatf("enc_win%0d", i), 64'(dig), 64'(enc_exp[i]));
        end

        tick();
        tick();
        check("reset_in_ready",  64'(in_ready),  64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_busy",      64'(busy),      64'(0));
        check("reset_p",         64'(p),         64'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            start_and_wait(vecs[i].s, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(vecs[i].lat));
            check($sformatf("vec%0d_p", i), 64'(p), 64'(vecs[i].p));
            tick();
            check($sformatf("vec%0d_back_idle", i), 64'({in_ready, out_valid, busy}), 64'(3'b100));
            check($sformatf("vec%0d_p_kept", i), 64'(p), 64'(vecs[i].p));
        end

        // Backpressure in DONE: result held, new operands ignored.
        out_ready = 1'b0;
        start_and_wait(1'b1, 16'h0006, 16'hFFFE, cyc);
        check("bp_latency", 64'(cyc), 64'(8));
        check("bp_p", 64'(p), 64'(32'hFFFF_FFF4));
        held_p    = p;
        in_valid  = 1'b1;
        a         = 16'h0011;
        b         = 16'h0022;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d_p", i), 64'(p), 64'(held_p));
            check($sformatf("bp_hold%0d_flags", i), 64'({in_ready, out_valid, busy}), 64'(3'b010));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        check("bp_release_p", 64'(p), 64'(held_p));

        // Reset during the 4th RUN cycle discards the in-flight product.
        is_signed = 1'b1;
        a         = 16'h0100;
        b         = 16'h0100;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        check("mid_busy", 64'(busy), 64'(1));
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        check("rst_p", 64'(p), 64'(0));
        tick();
        check("rst_stays_idle", 64'({in_ready, out_valid, busy}), 64'(3'b100));

        start_and_wait(1'b1, 16'h0002, 16'h0002, cyc);
        check("post_rst_latency", 64'(cyc), 64'(8));
        check("post_rst_p", 64'(p), 64'(4));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
